dcache_write_buffer: RTL
========================

// Module: dcache_write_buffer
// PURPOSE
//  Write-back buffer between the data cache (memory stage) and main memory via the arbiter.
//  Absorbs dirty-line evictions so a D-cache miss refill is not delayed by the writeback.
//  Drains entries in FIFO order through a req/grant/ack handshake.
//  Forwards buffered line data to cache refills (lookup) so a refill never reads stale memory.
//  Raises wb_full_stall toward stall_control when an eviction cannot be accepted.
// PARAMETERS
//  DEPTH      4    entries; power of two, >=2
//  PADDR_W    20   physical line-address width (byte address >> line offset)
//  LINE_W     128  cache line width in bits
// PORTS
//  clock          in   1        single clock; all state on posedge
//  rst            in   1        synchronous, active-high reset
//  push_valid     in   1        D-cache presents a dirty victim line
//  push_addr      in   PADDR_W  victim line address
//  push_data      in   LINE_W   victim line data
//  push_ready     out  1        entry accepted this cycle (= !full)
//  wb_full_stall  out  1        push_valid & full; to stall_control
//  lookup_addr    in   PADDR_W  refill line address from D-cache miss path
//  lookup_hit     out  1        a valid entry holds lookup_addr (comb)
//  lookup_data    out  LINE_W   data of youngest matching entry (comb; 0 if no hit)
//  mem_req        out  1        request memory port from arbiter
//  mem_grant      in   1        arbiter grant
//  mem_we         out  1        write strobe, high in WRITE state
//  mem_addr       out  PADDR_W  head entry address
//  mem_wdata      out  LINE_W   head entry data
//  mem_ack        in   1        memory has committed the write (1-cycle pulse)
//  empty, full    out  1        occupancy flags
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): all valid bits 0, head=tail=count=0, FSM=IDLE;
//    outputs next cycle: push_ready=1, empty=1, full=0, mem_req=0, mem_we=0, lookup_hit=0.
//  Storage: circular FIFO; head/tail are log2(DEPTH)-bit pointers wrapping mod DEPTH;
//    count is log2(DEPTH)+1 bits; full = (count==DEPTH), empty = (count==0).
//  Push: accepted iff push_valid & !full; writes slot[tail], tail++, count++.
//    No merging; a second eviction of the same line allocates a new entry.
//  FSM: IDLE -> REQ when !empty (mem_req=1 from the cycle after entering REQ's condition).
//    REQ: mem_req=1, mem_we=0; on mem_grant -> WRITE.
//    WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata = head, held stable until ack.
//    WRITE & mem_ack: pop head (valid=0, head++, count--) -> IDLE; mem_req drops next cycle.
//    mem_ack outside WRITE is ignored. Minimum drain: 3 cycles per entry (IDLE,REQ,WRITE).
//  Simultaneous push+pop: count unchanged; push_ready uses the pre-pop count
//    (a push to a full buffer is refused even when a pop occurs the same cycle).
//  Push into empty buffer: FSM sees !empty the following cycle (1-cycle push-to-req latency).
//  Lookup: associative over all valid entries, including the one being written;
//    multiple matches -> youngest (closest to tail) wins. Entry stays visible until popped.
//  wb_full_stall is combinational; D-cache must hold push_* stable while stalled.
//  Reset mid-WRITE: entries discarded, mem_req/mem_we low next cycle; arb releases on req drop.
// STRUCTURE
//  Shared header (preprocessor_directives.v): `WB_DEPTH, `LINE_W, FSM state codes
//    WB_IDLE=2'd0, WB_REQ=2'd1, WB_WRITE=2'd2.
//  One sub-module: wb_lookup_cam (DEPTH-way address compare + youngest-match priority select).
//  FIFO storage, pointers and FSM stay in this module.
// TESTING
//  1 reset, no traffic -> empty=1, push_ready=1, mem_req=0 for 10 cycles.
//  2 push A=0x00010/D0; grant 1 cycle after req; ack after 3 WRITE cycles -> mem_addr=0x00010,
//    mem_wdata=D0 stable whole WRITE, empty=1 cycle after ack.
//  3 grant withheld; push 4 lines -> full=1; 5th push -> push_ready=0, wb_full_stall=1;
//    grant+ack -> next cycle push_ready=1, 5th line accepted, drain order A,B,C,D,E.
//  4 push 0x00020/D1 then 0x00020/D2; lookup 0x00020 -> hit, data=D2; lookup 0x00030 -> hit=0, data=0.
//  5 full buffer, push_valid held while ack arrives -> push refused that cycle, accepted next; count=DEPTH.
//  6 rst asserted mid-WRITE -> next cycle mem_req=0, mem_we=0, empty=1; stray mem_ack ignored.

Source files
------------

// File: rtl/dcache_write_buffer_pkg.sv
// dcache_write_buffer_pkg: shared sizes and drain FSM state codes for the D-cache write-back buffer.
package dcache_write_buffer_pkg;
   localparam int WB_DEPTH = 4;
   localparam int PADDR_W  = 20;
   localparam int LINE_W   = 128;
   typedef enum logic [1:0] {
      WB_IDLE  = 2'd0,
      WB_REQ   = 2'd1,
      WB_WRITE = 2'd2
   } wb_state_e;
endpackage

// File: rtl/dcache_write_buffer_lookup_cam.sv
// wb_lookup_cam: associative address match over buffered lines, youngest match wins.
module wb_lookup_cam #(
   parameter int DEPTH = 4,
   parameter int AW    = 20,
   parameter int DW    = 128
) (
   input  logic [DEPTH-1:0]                 i_valid,
   input  logic [DEPTH-1:0][AW-1:0]         i_addr,
   input  logic [DEPTH-1:0][DW-1:0]         i_data,
   input  logic [$clog2(DEPTH)-1:0]         i_head,
   input  logic [AW-1:0]                    i_lookup_addr,
   output logic                             o_hit,
   output logic [DW-1:0]                    o_data
);
   localparam int PW = $clog2(DEPTH);
   logic [PW-1:0] w_idx;
   // Walk from oldest (head) to youngest so the last match overrides earlier ones.
   always_comb begin
      o_hit  = 1'b0;
      o_data = '0;
      w_idx  = i_head;
      for (int k = 0; k < DEPTH; k++) begin
         w_idx = i_head + PW'(k);
         if (i_valid[w_idx] && i_addr[w_idx] == i_lookup_addr) begin
            o_hit  = 1'b1;
            o_data = i_data[w_idx];
         end
      end
   end
endmodule

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: FIFO of dirty victim lines drained to memory via req/grant/ack,
// with refill forwarding from buffered lines.
module dcache_write_buffer
   import dcache_write_buffer_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int AW    = PADDR_W,
   parameter int DW    = LINE_W
) (
   input  logic          i_clock,
   input  logic          i_rst,
   input  logic          i_push_valid,
   input  logic [AW-1:0] i_push_addr,
   input  logic [DW-1:0] i_push_data,
   output logic          o_push_ready,
   output logic          o_wb_full_stall,
   input  logic [AW-1:0] i_lookup_addr,
   output logic          o_lookup_hit,
   output logic [DW-1:0] o_lookup_data,
   output logic          o_mem_req,
   input  logic          i_mem_grant,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic          i_mem_ack,
   output logic          o_empty,
   output logic          o_full
);
   localparam int PW = $clog2(DEPTH);
   wb_state_e                r_state, w_state_nxt;
   logic [DEPTH-1:0]         r_valid;
   logic [DEPTH-1:0][AW-1:0] r_addr;
   logic [DEPTH-1:0][DW-1:0] r_data;
   logic [PW-1:0]            r_head, r_tail;
   logic [PW:0]              r_count;
   logic                     w_push, w_pop;
   assign o_full          = r_count == (PW+1)'(DEPTH);
   assign o_empty         = r_count == '0;
   assign o_push_ready    = !o_full;
   assign o_wb_full_stall = i_push_valid & o_full;
   // Push is gated by the pre-pop count, so a full buffer refuses even while popping.
   assign w_push          = i_push_valid & !o_full;
   assign w_pop           = (r_state == WB_WRITE) & i_mem_ack;
   assign o_mem_req       = r_state != WB_IDLE;
   assign o_mem_we        = r_state == WB_WRITE;
   assign o_mem_addr      = r_addr[r_head];
   assign o_mem_wdata     = r_data[r_head];
   always_comb begin
      w_state_nxt = WB_IDLE;
      case (r_state)
         WB_IDLE:  w_state_nxt = o_empty ? WB_IDLE : WB_REQ;
         WB_REQ:   w_state_nxt = i_mem_grant ? WB_WRITE : WB_REQ;
         WB_WRITE: w_state_nxt = i_mem_ack ? WB_IDLE : WB_WRITE;
         default:  w_state_nxt = WB_IDLE;
      endcase
   end
   always_ff @(posedge i_clock) begin
      if (i_rst) begin
         r_state <= WB_IDLE;
         r_valid <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PW'(1);
         end
         if (w_pop) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PW'(1);
         end
         r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
   end
   always_ff @(posedge i_clock) begin
      if (w_push) begin
         r_addr[r_tail] <= i_push_addr;
         r_data[r_tail] <= i_push_data;
      end
   end
   wb_lookup_cam #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_cam (
      .i_valid      (r_valid),
      .i_addr       (r_addr),
      .i_data       (r_data),
      .i_head       (r_head),
      .i_lookup_addr(i_lookup_addr),
      .o_hit        (o_lookup_hit),
      .o_data       (o_lookup_data)
   );
endmodule
